// File: rtl/parking_gate_arbiter_pkg.sv
// parking_pkg: shared car-park types, 7-seg constants and helpers
package parking_pkg;
  typedef enum logic [1:0] {IDLE, OPENING, HOLD, CLOSING} gate_state_e;
  typedef enum logic {ENTRY, EXIT} lane_e;
  // 7-seg glyphs used by the lane FSMs (active-low, gfedcba order)
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_E     = 7'b000_0110;
  localparam logic [6:0] SEG_G     = 7'b100_0010;
  localparam logic [6:0] SEG_O     = 7'b100_0000;
  localparam logic [6:0] SEG_P     = 7'b000_1100;
  localparam logic [6:0] SEG_B     = 7'b000_0011;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/parking_gate_arbiter_if.sv
// parking_gate_arbiter_if: lane requests, gate command and occupancy status
interface parking_gate_arbiter_if #(parameter int CNT_W = 4);
  logic             entry_req;
  logic             exit_req;
  logic             pass_done;
  logic             gate_open;
  logic             entry_grant;
  logic             exit_grant;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             timeout;
  modport master (
    output entry_req, exit_req, pass_done,
    input  gate_open, entry_grant, exit_grant, occupancy, full, empty, timeout
  );
  modport slave (
    input  entry_req, exit_req, pass_done,
    output gate_open, entry_grant, exit_grant, occupancy, full, empty, timeout
  );
endinterface

// File: rtl/parking_gate_arbiter_gate_timer.sv
// gate_timer: loadable down-counter that parks at zero and flags done there
module gate_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins over counting; the count saturates at zero
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  // counter register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: round-robin gate sharing, open/hold/close sequencing, occupancy
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY    = 8,
  parameter int OPEN_CYCLES = 4,
  parameter int HOLD_MAX    = 16
) (
  input  logic                   clock_in,
  input  logic                   rst_in,
  parking_gate_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int TW    = $clog2(max_int(OPEN_CYCLES, HOLD_MAX) + 1);
  gate_state_e      state_q, state_d;
  lane_e            cur_lane_q, cur_lane_d, last_q, last_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             entry_grant_q, entry_grant_d;
  logic             exit_grant_q, exit_grant_d;
  logic             timeout_q, timeout_d;
  logic             t_load, t_done;
  logic [TW-1:0]    t_val;
  logic             full, empty, elig_en, elig_ex, grant_en, grant_ex;
  assign full     = occ_q == CNT_W'(CAPACITY);
  assign empty    = occ_q == '0;
  assign elig_en  = bus.entry_req && !full;
  assign elig_ex  = bus.exit_req && !empty;
  assign grant_en = elig_en && (!elig_ex || last_q == EXIT);
  assign grant_ex = elig_ex && (!elig_en || last_q == ENTRY);
  // one timer serves the travel phases (OPEN_CYCLES) and the hold window (HOLD_MAX)
  gate_timer #(.W(TW)) u_timer (
    .clk_i  (clock_in),
    .rst_ni (rst_in),
    .load_i (t_load),
    .val_i  (t_val),
    .done_o (t_done)
  );
  // state and registered pulses; reset aborts any phase at once
  always_ff @(posedge clock_in or negedge rst_in)
    if (!rst_in) begin
      state_q       <= IDLE;
      cur_lane_q    <= ENTRY;
      last_q        <= EXIT;
      occ_q         <= '0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_lane_q    <= cur_lane_d;
      last_q        <= last_d;
      occ_q         <= occ_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      timeout_q     <= timeout_d;
    end
  // next state: arbitrate in IDLE, time each phase, count cars on pass_done
  always_comb begin
    state_d       = state_q;
    cur_lane_d    = cur_lane_q;
    last_d        = last_q;
    occ_d         = occ_q;
    entry_grant_d = 1'b0;
    exit_grant_d  = 1'b0;
    timeout_d     = 1'b0;
    t_load        = 1'b0;
    t_val         = TW'(OPEN_CYCLES - 1);
    case (state_q)
      IDLE:
        if (grant_en || grant_ex) begin
          state_d       = OPENING;
          cur_lane_d    = grant_en ? ENTRY : EXIT;
          last_d        = grant_en ? ENTRY : EXIT;
          entry_grant_d = grant_en;
          exit_grant_d  = grant_ex;
          t_load        = 1'b1;
        end
      OPENING:
        if (t_done) begin
          state_d = HOLD;
          t_load  = 1'b1;
          t_val   = TW'(HOLD_MAX - 1);
        end
      HOLD:
        if (bus.pass_done) begin
          state_d = CLOSING;
          t_load  = 1'b1;
          occ_d   = cur_lane_q == ENTRY ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
        end else if (t_done) begin
          state_d   = CLOSING;
          t_load    = 1'b1;
          timeout_d = 1'b1;
        end
      CLOSING:
        if (t_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs: barrier is commanded open while opening and holding
  always_comb begin
    bus.gate_open   = state_q == OPENING || state_q == HOLD;
    bus.entry_grant = entry_grant_q;
    bus.exit_grant  = exit_grant_q;
    bus.timeout     = timeout_q;
    bus.occupancy   = occ_q;
    bus.full        = full;
    bus.empty       = empty;
  end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed gate-cycle scenarios with hand-computed expectations
module tb_parking_gate_arbiter;
  logic clock_in = 1'b0;
  logic rst_in   = 1'b0;
  int   n_cmp = 0, n_bad = 0;
  int   go_cnt, to_cnt, eg_cnt, xg_cnt;
  int   lane;

  parking_gate_arbiter_if #(.CNT_W(2)) bus ();

  parking_gate_arbiter #(
    .CAPACITY    (2),
    .OPEN_CYCLES (4),
    .HOLD_MAX    (16)
  ) dut (
    .clock_in (clock_in),
    .rst_in   (rst_in),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear();
    go_cnt = 0; to_cnt = 0; eg_cnt = 0; xg_cnt = 0;
  endtask

  // advance to the next falling edge and tally the observed outputs
  task automatic tick();
    @(negedge clock_in);
    if (bus.gate_open)   go_cnt++;
    if (bus.timeout)     to_cnt++;
    if (bus.entry_grant) eg_cnt++;
    if (bus.exit_grant)  xg_cnt++;
  endtask

  // one full gate cycle; pass_at = HOLD cycle carrying pass_done, 0 = never; ends in IDLE
  task automatic gate_cycle(input logic ent, input logic ext, input int pass_at, output int ln);
    clear();
    bus.entry_req = ent;
    bus.exit_req  = ext;
    ln = -1;
    for (int i = 0; i < 20 && ln < 0; i++) begin
      tick();
      if (bus.entry_grant)     ln = 0;
      else if (bus.exit_grant) ln = 1;
    end
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    if (ln < 0) check("grant_wait", 0, 1);
    else if (pass_at > 0) begin
      repeat (3 + pass_at) tick();
      bus.pass_done = 1'b1;
      tick();
      bus.pass_done = 1'b0;
      repeat (4) tick();
    end else repeat (24) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    bus.pass_done = 1'b0;
    @(negedge clock_in);
    check("rst_gate_open", bus.gate_open, 0);
    check("rst_entry_grant", bus.entry_grant, 0);
    check("rst_exit_grant", bus.exit_grant, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_full", bus.full, 0);
    check("rst_empty", bus.empty, 1);
    rst_in = 1'b1;
    // single entry, pass on 2nd HOLD cycle
    gate_cycle(1, 0, 2, lane);
    check("single_lane", lane, 0);
    check("single_eg", eg_cnt, 1);
    check("single_xg", xg_cnt, 0);
    check("single_open", go_cnt, 6);
    check("single_to", to_cnt, 0);
    check("single_occ", bus.occupancy, 1);
    check("single_empty", bus.empty, 0);
    // exit with no pass: timeout, occupancy kept, last served becomes exit
    gate_cycle(0, 1, 0, lane);
    check("to_lane", lane, 1);
    check("to_open", go_cnt, 20);
    check("to_pulse", to_cnt, 1);
    check("to_occ", bus.occupancy, 1);
    // ties at occupancy 1 alternate entry, exit, entry
    gate_cycle(1, 1, 0, lane);
    check("tie1_lane", lane, 0);
    gate_cycle(1, 1, 0, lane);
    check("tie2_lane", lane, 1);
    gate_cycle(1, 1, 0, lane);
    check("tie3_lane", lane, 0);
    check("tie3_to", to_cnt, 1);
    check("tie_occ", bus.occupancy, 1);
    // pass_done on the 16th HOLD cycle beats expiry
    gate_cycle(1, 0, 16, lane);
    check("exp_lane", lane, 0);
    check("exp_to", to_cnt, 0);
    check("exp_open", go_cnt, 20);
    check("exp_occ", bus.occupancy, 2);
    check("exp_full", bus.full, 1);
    // entry blocked while full
    clear();
    bus.entry_req = 1'b1;
    repeat (12) tick();
    bus.entry_req = 1'b0;
    check("blk_eg", eg_cnt, 0);
    check("blk_open", go_cnt, 0);
    check("blk_full", bus.full, 1);
    gate_cycle(1, 1, 1, lane);
    check("blk_exit_lane", lane, 1);
    check("blk_exit_occ", bus.occupancy, 1);
    check("blk_exit_full", bus.full, 0);
    gate_cycle(1, 1, 3, lane);
    check("after_exit_lane", lane, 0);
    check("after_exit_open", go_cnt, 7);
    check("after_exit_occ", bus.occupancy, 2);
    // asynchronous reset in the middle of HOLD
    clear();
    bus.exit_req = 1'b1;
    lane = -1;
    for (int i = 0; i < 20 && lane < 0; i++) begin
      tick();
      if (bus.exit_grant) lane = 1;
    end
    bus.exit_req = 1'b0;
    check("mid_grant", lane, 1);
    repeat (5) tick();
    check("mid_hold_open", bus.gate_open, 1);
    #2 rst_in = 1'b0;
    #1;
    check("mid_rst_open", bus.gate_open, 0);
    check("mid_rst_occ", bus.occupancy, 0);
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_full", bus.full, 0);
    @(negedge clock_in);
    rst_in = 1'b1;
    tick();
    check("post_rst_idle", bus.gate_open, 0);
    gate_cycle(1, 1, 1, lane);
    check("post_rst_tie", lane, 0);
    check("post_rst_occ", bus.occupancy, 1);
    gate_cycle(1, 1, 1, lane);
    check("post_rst_tie2", lane, 1);
    check("post_rst_occ2", bus.occupancy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
